// File: rtl/home_alert_if.sv
// Status bus between the home-automation controller (master) and the
// alert driver (slave). The master side drives the state code, the one-hot
// actuator word and the acknowledge; the slave side returns the physical
// I/O drives and status.
interface home_alert_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       display;
    logic [5:0]       output_signals;
    logic             ack;
    logic [6:0]       seg;
    logic             buzzer;
    logic             heater_on;
    logic             cooler_on;
    logic             mismatch_err;
    logic [CNT_W-1:0] event_count;

    modport master (
        output display, output_signals, ack,
        input  seg, buzzer, heater_on, cooler_on, mismatch_err, event_count
    );

    modport slave (
        input  display, output_signals, ack,
        output seg, buzzer, heater_on, cooler_on, mismatch_err, event_count
    );
endinterface

// File: rtl/home_alert_driver.sv
// home_alert_driver: receiving end of the controller status interface.
// Two-stage pipeline: stage 1 captures display/output_signals, stage 2
// registers every output from the captured code, so a display change
// reaches the outputs two edges later.
// Optional feature: define FIRE_LATCH_EN to keep the buzzer sounding after
// a fire event until acknowledged.
module home_alert_driver #(
    parameter int CLK_DIV = 16,
    parameter int MIN_ON  = 8,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    home_alert_if.slave bus
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OW = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [OW-1:0] ON_LAST  = OW'(MIN_ON - 1);

    typedef enum logic [1:0] {A_OFF, A_HEAT, A_COOL, A_DEAD} act_e;

    // Segment pattern (gfedcba) for each state letter.
    function automatic logic [6:0] seg_lut(input logic [2:0] c);
        logic [6:0] r;
        r = 7'h40;
        case (c)
            3'd0: r = 7'h40;
            3'd1: r = 7'h71;
            3'd2: r = 7'h50;
            3'd3: r = 7'h77;
            3'd4: r = 7'h3E;
            3'd5: r = 7'h76;
            3'd6: r = 7'h39;
            default: r = 7'h79;
        endcase
        return r;
    endfunction

    // Actuator word the controller must present for a given state code.
    function automatic logic [5:0] exp_sig(input logic [2:0] c);
        logic [5:0] r;
        r = '0;
        if (c >= 3'd1 && c <= 3'd6) r = 6'd1 << (c - 3'd1);
        return r;
    endfunction

    // Stage 1 and pipeline state
    logic [2:0]       disp_q, disp_qq;
    logic [5:0]       sig_q;
    logic [1:0]       vld_pipe_q;
    logic [PW-1:0]    pre_q, pre_d;
    logic [1:0]       phase_q, phase_d;
    logic             buzz_q, buzz_d;
    logic [CNT_W-1:0] ev_q, ev_d;
    logic             mm_q, mm_d;
    logic [6:0]       seg_q;
    logic             heat_q, cool_q;
    act_e             state_q, state_d;
    logic [OW-1:0]    on_cnt_q, on_cnt_d;

    logic changed, tick, tgl_mode, heat_req, cool_req, chk_bad;

    assign changed  = (disp_q != disp_qq);
    assign tick     = (pre_q == PRE_LAST);
    assign heat_req = (disp_q == 3'd5);
    assign cool_req = (disp_q == 3'd6);
    // Sig lags display by one clock, so it is judged against disp_qq.
    assign chk_bad  = (disp_qq == 3'd7) || (sig_q != exp_sig(disp_qq));

`ifdef FIRE_LATCH_EN
    logic fire_q, fire_d;

    // Fire latch: set on entry into code 3, cleared by ack once code 3 is gone.
    always_comb begin
        fire_d = fire_q;
        if (disp_q == 3'd3 && changed)
            fire_d = 1'b1;
        else if (bus.ack && disp_q != 3'd3)
            fire_d = 1'b0;
    end

    // Fire latch register.
    always_ff @(posedge clk) begin
        if (rst) fire_q <= 1'b0;
        else     fire_q <= fire_d;
    end

    assign tgl_mode = (disp_q == 3'd3) || fire_q;
`else
    logic unused_ack;
    assign unused_ack = bus.ack;
    assign tgl_mode   = (disp_q == 3'd3);
`endif

    // Stage 1 capture plus the valid shift that holds off the protocol check.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q     <= '0;
            disp_qq    <= '0;
            sig_q      <= '0;
            vld_pipe_q <= '0;
        end else begin
            disp_q     <= bus.display;
            disp_qq    <= disp_q;
            sig_q      <= bus.output_signals;
            vld_pipe_q <= {vld_pipe_q[0], 1'b1};
        end
    end

    // Next-state for prescaler, buzzer phase/drive, event counter, sticky error.
    always_comb begin
        pre_d   = tick ? '0 : pre_q + 1'b1;

        phase_d = phase_q;
        if (changed)   phase_d = 2'd0;
        else if (tick) phase_d = phase_q + 2'd1;

        buzz_d = 1'b0;
        if (tgl_mode)
            buzz_d = tick ? ~buzz_q : buzz_q;
        else if (disp_q == 3'd1 || disp_q == 3'd2 || disp_q == 3'd4)
            buzz_d = (phase_d == 2'd0);

        ev_d = ev_q;
        if (disp_q >= 3'd1 && disp_q <= 3'd4 && changed && ev_q != '1)
            ev_d = ev_q + 1'b1;

        mm_d = mm_q | (vld_pipe_q[1] & chk_bad);
    end

    // Actuator FSM: minimum on-time hold, one dead cycle between relays.
    // The dead cycle resolves requests like A_OFF so a waiting request
    // starts its relay right after the single dead clock.
    always_comb begin
        state_d  = state_q;
        on_cnt_d = on_cnt_q;
        case (state_q)
            A_OFF, A_DEAD: begin
                state_d = A_OFF;
                if (heat_req) begin
                    state_d  = A_HEAT;
                    on_cnt_d = '0;
                end else if (cool_req) begin
                    state_d  = A_COOL;
                    on_cnt_d = '0;
                end
            end
            A_HEAT: begin
                if (on_cnt_q != ON_LAST) on_cnt_d = on_cnt_q + 1'b1;
                if (!heat_req && on_cnt_q == ON_LAST) state_d = A_DEAD;
            end
            A_COOL: begin
                if (on_cnt_q != ON_LAST) on_cnt_d = on_cnt_q + 1'b1;
                if (!cool_req && on_cnt_q == ON_LAST) state_d = A_DEAD;
            end
            default: state_d = A_OFF;
        endcase
    end

    // Stage 2 registers: timing/FSM state and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q    <= '0;
            phase_q  <= '0;
            buzz_q   <= 1'b0;
            ev_q     <= '0;
            mm_q     <= 1'b0;
            seg_q    <= 7'h40;
            state_q  <= A_OFF;
            on_cnt_q <= '0;
            heat_q   <= 1'b0;
            cool_q   <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            phase_q  <= phase_d;
            buzz_q   <= buzz_d;
            ev_q     <= ev_d;
            mm_q     <= mm_d;
            seg_q    <= seg_lut(disp_q);
            state_q  <= state_d;
            on_cnt_q <= on_cnt_d;
            heat_q   <= (state_d == A_HEAT);
            cool_q   <= (state_d == A_COOL);
        end
    end

    assign bus.seg          = seg_q;
    assign bus.buzzer       = buzz_q;
    assign bus.heater_on    = heat_q;
    assign bus.cooler_on    = cool_q;
    assign bus.mismatch_err = mm_q;
    assign bus.event_count  = ev_q;

endmodule

// File: tb/tb_home_alert_driver.sv
// Directed bench for home_alert_driver: a vector table for seg/event_count,
// plus hand sequences for relay hold, buzzer cadence and protocol errors.
module tb_home_alert_driver;
    localparam int CLK_DIV = 4;
    localparam int MIN_ON  = 8;
    localparam int CNT_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    home_alert_if #(.CNT_W(CNT_W)) bus ();

    home_alert_driver #(.CLK_DIV(CLK_DIV), .MIN_ON(MIN_ON), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] d;
        logic [6:0] seg;
        logic [7:0] evc;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] onehot(input logic [2:0] c);
        case (c)
            3'd1: return 6'b000001;
            3'd2: return 6'b000010;
            3'd3: return 6'b000100;
            3'd4: return 6'b001000;
            3'd5: return 6'b010000;
            3'd6: return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    // Inputs change 1 time unit after an edge; outputs are read at the same point.
    task automatic step_raw(input logic [2:0] d, input logic [5:0] s);
        bus.display        = d;
        bus.output_signals = s;
        @(posedge clk);
        #1;
    endtask

    // Well-behaved controller: actuator word follows display one clock later.
    task automatic step(input logic [2:0] d);
        step_raw(d, onehot(bus.display));
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.ack = 1'b0;
        step_raw(3'd0, 6'd0);
        step_raw(3'd0, 6'd0);
        rst = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_seg"},  bus.seg, 7'h40);
        chk({tag, "_outs"}, {bus.buzzer, bus.heater_on, bus.cooler_on, bus.mismatch_err}, 4'b0000);
        chk({tag, "_evc"},  bus.event_count, 8'd0);
    endtask

    // Buzzer must toggle exactly every CLK_DIV clocks while code d is shown.
    task automatic toggle_check(input string name, input logic [2:0] d);
        logic b [0:47];
        int t;
        int bad;
        t = -1;
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            step(d);
            b[i] = bus.buzzer;
        end
        for (int i = 1; i < 20; i++)
            if (t < 0 && b[i] != b[i-1]) t = i;
        if (t < 0) begin
            chk({name, "_found"}, 0, 1);
        end else begin
            for (int k = t + 1; k <= t + 24; k++)
                if ((b[k] != b[k-1]) != (((k - t) % CLK_DIV) == 0)) bad++;
            chk(name, bad, 0);
        end
    endtask

    initial begin
        logic [31:0] hm, cm;
        int both, f, bad;
        logic b1 [0:47];

        tbl[0] = '{3'd0, 7'h40, 8'd0};
        tbl[1] = '{3'd1, 7'h71, 8'd1};
        tbl[2] = '{3'd2, 7'h50, 8'd2};
        tbl[3] = '{3'd3, 7'h77, 8'd3};
        tbl[4] = '{3'd4, 7'h3E, 8'd4};
        tbl[5] = '{3'd5, 7'h76, 8'd4};
        tbl[6] = '{3'd6, 7'h39, 8'd4};
        tbl[7] = '{3'd0, 7'h40, 8'd4};
        tbl[8] = '{3'd4, 7'h3E, 8'd5};
        tbl[9] = '{3'd1, 7'h71, 8'd6};

        bus.display = 3'd0;
        bus.output_signals = 6'd0;
        bus.ack = 1'b0;

        // Reset state and idle
        do_reset();
        chk_idle("reset");
        for (int i = 0; i < 10; i++) step(3'd0);
        chk_idle("idle");

        // Vector table: seg letter and event counting
        for (int v = 0; v < 10; v++) begin
            for (int c = 0; c < 3; c++) step(tbl[v].d);
            chk($sformatf("vec%0d_seg", v), bus.seg, tbl[v].seg);
            chk($sformatf("vec%0d_evc", v), bus.event_count, tbl[v].evc);
            chk($sformatf("vec%0d_mm", v), bus.mismatch_err, 1'b0);
        end

        // Heater minimum on-time: 5 for 3 clocks then 0
        do_reset();
        hm = '0; cm = '0;
        for (int i = 1; i <= 14; i++) begin
            step(i <= 3 ? 3'd5 : 3'd0);
            hm[i] = bus.heater_on;
            cm[i] = bus.cooler_on;
        end
        chk("heat_hold", hm, 32'h0000_03FC);
        chk("heat_nocool", cm, 32'h0);

        // Heat then cool request: no preemption, one dead clock
        do_reset();
        hm = '0; cm = '0; both = 0;
        for (int i = 1; i <= 16; i++) begin
            step(i == 1 ? 3'd5 : 3'd6);
            hm[i] = bus.heater_on;
            cm[i] = bus.cooler_on;
            if (bus.heater_on && bus.cooler_on) both++;
        end
        chk("handoff_heat", hm, 32'h0000_03FC);
        chk("handoff_cool", cm, 32'h0001_F800);
        chk("handoff_both", both, 0);

        // Reset mid-hold drops the relay at the next edge
        do_reset();
        for (int i = 0; i < 4; i++) step(3'd5);
        chk("midhold_on", bus.heater_on, 1'b1);
        rst = 1'b1;
        step(3'd0);
        chk("midhold_rst", bus.heater_on, 1'b0);

        // Buzzer: code 3 toggles every tick, code 1 is 4 high / 12 low
        do_reset();
        toggle_check("buz_fa", 3'd3);
        for (int i = 0; i < 48; i++) begin
            step(3'd1);
            b1[i] = bus.buzzer;
        end
        f = -1;
        for (int i = 1; i < 17; i++)
            if (f < 0 && b1[i-1] && !b1[i]) f = i;
        if (f < 0) begin
            chk("buz_fd_fall", 0, 1);
        end else begin
            bad = 0;
            for (int k = 0; k < 32; k++)
                if (b1[f+k] != ((k % 16) >= 12)) bad++;
            chk("buz_fd_pattern", bad, 0);
        end

        // Mismatch: wrong word one clock after display=2
        do_reset();
        for (int i = 0; i < 3; i++) step(3'd0);
        step_raw(3'd2, 6'b000000);
        step_raw(3'd2, 6'b000001);
        chk("mm_before", bus.mismatch_err, 1'b0);
        step(3'd2);
        chk("mm_set", bus.mismatch_err, 1'b1);
        for (int i = 0; i < 100; i++) step(3'd0);
        chk("mm_sticky", bus.mismatch_err, 1'b1);
        do_reset();
        chk("mm_cleared", bus.mismatch_err, 1'b0);

        // Check is suppressed right after reset release
        step_raw(3'd0, 6'b111111);
        for (int i = 0; i < 4; i++) step(3'd0);
        chk("mm_suppressed", bus.mismatch_err, 1'b0);

        // Illegal code 7 always flags
        for (int i = 0; i < 3; i++) step(3'd7);
        chk("code7_seg", bus.seg, 7'h79);
        chk("code7_mm", bus.mismatch_err, 1'b1);

        // Event counter saturation
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(3'd1);
            step(3'd0);
        end
        step(3'd0);
        chk("evc_10", bus.event_count, 8'd10);
        for (int i = 0; i < 290; i++) begin
            step(3'd1);
            step(3'd0);
        end
        step(3'd0);
        chk("evc_sat", bus.event_count, 8'd255);
        chk("evc_mm", bus.mismatch_err, 1'b0);

`ifdef FIRE_LATCH_EN
        // Fire latch keeps buzzer toggling after code 3 until ack
        do_reset();
        for (int i = 0; i < 3; i++) step(3'd3);
        bus.ack = 1'b1;
        step(3'd3);
        bus.ack = 1'b0;
        toggle_check("fire_hold", 3'd0);
        bus.ack = 1'b1;
        step(3'd0);
        bus.ack = 1'b0;
        for (int i = 0; i < 3; i++) step(3'd0);
        chk("fire_ack", bus.buzzer, 1'b0);
`else
        // Without the latch the buzzer falls silent once code 3 is gone
        do_reset();
        for (int i = 0; i < 3; i++) step(3'd3);
        for (int i = 0; i < 3; i++) step(3'd0);
        chk("nofire_quiet", bus.buzzer, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
